univ_shift_seq: RTL and testbench

- Command sequencer for the universal shifter (univ_shifter, N-bit, 2-bit control).
- Accepts one shift command at a time over a valid/ready handshake: data, direction and shift amount.
- Loads the shifter, drives the shift control for the requested number of cycles, then returns the shifted word over a valid/ready response port.
- Sits between a requesting block and univ_shifter, and is the only agent driving the shifter's control and data pins.

---
 rtl/univ_shift_pkg.sv | 21 ++
 rtl/univ_shifter.sv | 27 ++
 rtl/univ_shift_seq.sv | 94 +++++++++
 tb/tb_univ_shift_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_pkg.sv
// rtl/univ_shift_pkg.sv - shared types and constants for univ_shifter and its command sequencer
package univ_shift_pkg;

  typedef enum logic [1:0] {
    CTRL_HOLD = 2'd0,
    CTRL_SHR  = 2'd1,
    CTRL_SHL  = 2'd2,
    CTRL_LOAD = 2'd3
  } shf_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/univ_shifter.sv
// rtl/univ_shifter.sv - N-bit universal shift register (hold, shift right/left with zero fill, load)
module univ_shifter
  import univ_shift_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   control,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      case (shf_ctrl_e'(control))
        CTRL_SHR:  q <= {1'b0, q[N-1:1]};
        CTRL_SHL:  q <= {q[N-2:0], 1'b0};
        CTRL_LOAD: q <= d;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/univ_shift_seq.sv
// rtl/univ_shift_seq.sv - command sequencer: loads univ_shifter, shifts amt times, returns the word
module univ_shift_seq
  import univ_shift_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [N-1:0]     cmd_data,
  output logic [1:0]       shf_control,
  output logic [N-1:0]     shf_data,
  input  logic [N-1:0]     shf_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
  output logic             busy
);

  seq_state_e       r_state;
  logic             r_dir;
  logic [CNT_W-1:0] r_amt;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_data;

  logic             w_cmd_fire;
  logic [CNT_W-1:0] w_amt_clamped;

  assign w_cmd_fire    = cmd_valid & cmd_ready;
  assign w_amt_clamped = (cmd_amt > CNT_W'(N)) ? CNT_W'(N) : cmd_amt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_RIGHT;
      r_amt   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            r_dir   <= cmd_dir;
            r_data  <= cmd_data;
            r_amt   <= w_amt_clamped;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (r_amt == '0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt   <= r_amt;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs depend only on state and captured command, never on cmd_* or rsp_ready.
  always_comb begin
    shf_control = CTRL_HOLD;
    rsp_data    = '0;
    case (r_state)
      ST_LOAD:  shf_control = CTRL_LOAD;
      ST_SHIFT: shf_control = (r_dir == DIR_LEFT) ? CTRL_SHL : CTRL_SHR;
      ST_RESP:  rsp_data    = shf_out;
      default:  shf_control = CTRL_HOLD;
    endcase
  end

  assign shf_data  = r_data;
  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_univ_shift_seq.sv
// tb/tb_univ_shift_seq.sv - directed self-checking bench for univ_shift_seq driving univ_shifter
module tb_univ_shift_seq;
  import univ_shift_pkg::*;

  localparam int N     = 16;
  localparam int CNT_W = $clog2(N) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             shf_rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_amt;
  logic [N-1:0]     cmd_data;
  logic [1:0]       shf_control;
  logic [N-1:0]     shf_data;
  logic [N-1:0]     shf_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_data;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  univ_shift_seq #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .shf_control(shf_control), .shf_data(shf_data), .shf_out(shf_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  univ_shifter #(.N(N)) shifter (
    .clk(clk), .rst_n(shf_rst_n), .control(shf_control), .d(shf_data), .q(shf_out)
  );

  // Returns 1 ns after the accepting edge; the next negedge is the LOAD cycle.
  task automatic send_cmd(input logic [N-1:0] data, input logic dir, input logic [CNT_W-1:0] amt);
    @(negedge clk);
    cmd_data  = data;
    cmd_dir   = dir;
    cmd_amt   = amt;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    shf_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (shf_control !== 2'd0) begin errors++; $display("FAIL reset_ctrl: got %0d expected 0", shf_control); end
    checks++; if (shf_data !== 16'h0000) begin errors++; $display("FAIL reset_shf_data: got %h expected 0000", shf_data); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0000", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset     = 1'b1;
    shf_rst_n = 1'b1;
  endtask

  task automatic test_shift_left;
    logic [1:0] exp_ctl;
    send_cmd(16'h00FF, 1'b1, 5'd4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_ctl = (i == 0) ? 2'd3 : (i <= 4) ? 2'd2 : 2'd0;
      checks++; if (shf_control !== exp_ctl) begin errors++; $display("FAIL shl_ctrl[%0d]: got %0d expected %0d", i, shf_control, exp_ctl); end
      checks++; if (rsp_valid !== (i == 5)) begin errors++; $display("FAIL shl_rsp_valid[%0d]: got %b expected %b", i, rsp_valid, (i == 5)); end
    end
    checks++; if (rsp_data !== 16'h0FF0) begin errors++; $display("FAIL shl_rsp_data: got %h expected 0ff0", rsp_data); end
    finish_rsp();
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL shl_idle: got ready=%b busy=%b expected ready=1 busy=0", cmd_ready, busy); end
  endtask

  task automatic test_shift_right;
    logic [1:0] exp_ctl;
    send_cmd(16'h0080, 1'b0, 5'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_ctl = (i == 0) ? 2'd3 : (i <= 3) ? 2'd1 : 2'd0;
      checks++; if (shf_control !== exp_ctl) begin errors++; $display("FAIL shr_ctrl[%0d]: got %0d expected %0d", i, shf_control, exp_ctl); end
      checks++; if (rsp_valid !== (i == 4)) begin errors++; $display("FAIL shr_rsp_valid[%0d]: got %b expected %b", i, rsp_valid, (i == 4)); end
    end
    checks++; if (rsp_data !== 16'h0010) begin errors++; $display("FAIL shr_rsp_data: got %h expected 0010", rsp_data); end
    finish_rsp();
  endtask

  task automatic test_zero_amt;
    send_cmd(16'hA5A5, 1'b1, 5'd0);
    @(negedge clk);
    checks++; if (shf_control !== 2'd3 || rsp_valid !== 1'b0) begin errors++; $display("FAIL zero_load: got ctrl=%0d valid=%b expected ctrl=3 valid=0", shf_control, rsp_valid); end
    @(negedge clk);
    checks++; if (shf_control !== 2'd0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL zero_resp: got ctrl=%0d valid=%b expected ctrl=0 valid=1", shf_control, rsp_valid); end
    checks++; if (rsp_data !== 16'hA5A5) begin errors++; $display("FAIL zero_rsp_data: got %h expected a5a5", rsp_data); end
    finish_rsp();
  endtask

  task automatic test_clamp;
    int shl_cycles = 0;
    send_cmd(16'hFFFF, 1'b1, 5'd20);
    @(negedge clk);
    checks++; if (shf_control !== 2'd3) begin errors++; $display("FAIL clamp_load: got %0d expected 3", shf_control); end
    for (int i = 0; i < 24 && rsp_valid !== 1'b1; i++) begin
      @(negedge clk);
      if (shf_control === 2'd2) shl_cycles++;
    end
    checks++; if (shl_cycles != 16) begin errors++; $display("FAIL clamp_shl_cycles: got %0d expected 16", shl_cycles); end
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0000) begin errors++; $display("FAIL clamp_rsp: got valid=%b data=%h expected valid=1 data=0000", rsp_valid, rsp_data); end
    finish_rsp();
  endtask

  task automatic test_backpressure;
    send_cmd(16'h1234, 1'b1, 5'd1);
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_enter_resp: got %b expected 1", rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i == 1);
      cmd_data  = 16'hBEEF;
      cmd_amt   = 5'd2;
      cmd_dir   = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h2468) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected valid=1 data=2468", i, rsp_valid, rsp_data); end
      checks++; if (shf_control !== 2'd0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ctrl[%0d]: got ctrl=%0d ready=%b expected ctrl=0 ready=0", i, shf_control, cmd_ready); end
    end
    cmd_valid = 1'b0;
    finish_rsp();
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || shf_data !== 16'h1234) begin errors++; $display("FAIL bp_no_accept: got ready=%b shf_data=%h expected ready=1 shf_data=1234", cmd_ready, shf_data); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_stays_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_async_reset;
    send_cmd(16'h00FF, 1'b1, 5'd8);
    repeat (3) @(negedge clk);
    checks++; if (shf_control !== 2'd2) begin errors++; $display("FAIL ar_in_shift: got %0d expected 2", shf_control); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (shf_control !== 2'd0 || shf_data !== 16'h0000) begin errors++; $display("FAIL ar_shf: got ctrl=%0d data=%h expected ctrl=0 data=0000", shf_control, shf_data); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ar_ready_busy: got ready=%b busy=%b expected ready=1 busy=0", cmd_ready, busy); end
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000) begin errors++; $display("FAIL ar_rsp: got valid=%b data=%h expected valid=0 data=0000", rsp_valid, rsp_data); end
    @(negedge clk);
    reset = 1'b1;
    send_cmd(16'h0001, 1'b1, 5'd1);
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0002) begin errors++; $display("FAIL ar_recover: got valid=%b data=%h expected valid=1 data=0002", rsp_valid, rsp_data); end
    finish_rsp();
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_amt   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_shift_left();
    test_shift_right();
    test_zero_amt();
    test_clamp();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
